sparse_decoder_vec: RTL and testbench
=====================================

Name: sparse_decoder_vec

Overview:
Multi-lane successor of the single-lane run-length decoder. Each input beat carries LANES (skip, value) pairs, a lane mask and an end-of-vector flag. The block resolves every valid lane to its absolute (index, value) position in one pass using a lane prefix sum. It sits between the SRAM read path and the comparison block, and sustains one beat per cycle.

Parameters:
LANES, 4, pairs per beat (>=1)
SKIP_W, 8, width of each skip field
VALUE_W, 8, width of each value field
INDEX_W, 16, width of each output index
VEC_LEN, 1024, legal index range per vector is 0..VEC_LEN-1 (VEC_LEN <= 2^INDEX_W)

Ports:
mac_clk  in  1  clock
mac_rst  in  1  synchronous, active-high reset
sram_valid_i  in  1  input beat valid
sram_ready_o  out  1  input beat accepted when valid & ready
sram_skip_i  in  LANES*SKIP_W  per-lane zero-run length, lane 0 in the LSBs
sram_value_i  in  LANES*VALUE_W  per-lane nonzero value
sram_mask_i  in  LANES  per-lane valid; any pattern is legal
sram_last_i  in  1  beat closes the current vector
decoder_valid_o  out  1  output beat valid
decoder_ready_i  in  1  downstream accepts output beat
decoder_index_o  out  LANES*INDEX_W  resolved index per lane
decoder_value_o  out  LANES*VALUE_W  value per lane
decoder_mask_o  out  LANES  copy of the input mask
decoder_last_o  out  1  copy of sram_last_i
decoder_err_o  out  1  beat contains an out-of-range index

Behaviour:
- Reset, synchronous and high for one or more edges:
  - s1_valid=0, skid empty, decoder_valid_o=0.
  - nxt (next free index) = 0.
  - All data outputs = 0; sram_ready_o=1 on the cycle after reset releases.
- Pipeline: input register s1, then combinational prefix sum, then a 2-entry output skid.
  - Latency is 2 cycles from accept to decoder_valid_o.
  - Throughput is 1 beat/cycle.
- Ready: sram_ready_o = ~s1_valid | skid_ready. skid_ready is a registered flop. No combinational path runs from decoder_ready_i to sram_ready_o.
- Prefix sum, for a beat in s1:
  - P_k = sum over j<=k with mask_j of (skip_j+1).
  - For each masked lane k: index_k = nxt + P_k - 1.
  - Masked-off lanes output index=0 and value=0.
  - Computed at full precision (INDEX_W + clog2(LANES) + 1 bits), then truncated to INDEX_W (wraps modulo 2^INDEX_W).
- nxt update occurs only when s1 transfers into the skid:
  - last=1: nxt <= 0.
  - Otherwise: nxt <= nxt + P_(LANES-1), truncated.
  - mask=0 & last=0: beat forwarded, nxt unchanged.
  - mask=0 & last=1: beat forwarded and nxt resets to 0.
- Handshake: output data and valid hold stable while decoder_valid_o & ~decoder_ready_i. Beat order is preserved. No beat is dropped or duplicated.
- Full condition: s1 holds a beat and the skid holds 2 beats. At most 3 beats are outstanding; sram_ready_o=0 in this state.
- Simultaneous accept into s1 and transfer out of s1 is legal (full throughput).
- Reset mid-stream discards every in-flight beat. The first beat after reset starts a new vector at nxt=0.

Optional Feature:
DECODER_BOUNDS_CHECK_EN
- Defined:
  - decoder_err_o=1 for a beat if any masked lane's full-precision index is >= VEC_LEN.
  - The beat is still forwarded unchanged.
  - decoder_err_o is registered alongside the beat data.
- Undefined: decoder_err_o is tied 0 and no comparison logic is built.

Decomposition:
- Add to sparse_mac_pkg:
  - typedef dec_lane_t {skip, value}.
  - typedef dec_out_lane_t {index, value}.
  - Defaults DEC_LANES, DEC_INDEX_W, DEC_VEC_LEN.
- Sub-module skid_buffer_sync:
  - Parameter DATA_W.
  - Ports mac_clk/mac_rst (sync, active-high), valid_i/ready_o/data_i, valid_o/ready_i/data_o.
  - 2 entries, with registered ready_o.

Test Plan:
1. LANES=4, one beat skip={3,4,0,0}, value={5,6,0,0}, mask=0011, last=1 -> index={3,8,0,0}, value={5,6,0,0}, 2 cycles after accept; next beat skip0=2, mask=0001 -> index0=2.
2. Beat A skip={0,0,0,0}, mask=1111, last=0 -> index={0,1,2,3}; beat B skip0=2, mask=0001 -> index0=6.
3. mask=1011, skip={1,1,9,1} -> lane0=1, lane1=3, lane2 index=0 and value=0, lane3=5; nxt advances by 6.
4. Back-to-back 6 beats with decoder_ready_i=0 for 5 cycles -> exactly 3 beats accepted, then sram_ready_o=0; after release, all 6 beats emerge in order with correct indices.
5. VEC_LEN=16, beats skip0=15 then skip0=0 (mask=0001, same vector) -> indices 15 and 16; err = 0 then 1 with the macro defined, 0 and 0 without.
6. Fill s1 and the skid, then assert mac_rst for 1 cycle -> decoder_valid_o=0 next cycle; next beat skip0=2 -> index0=2.

Source files
------------

// File: rtl/sparse_mac_pkg.sv
// rtl/sparse_mac_pkg.sv - shared lane types and default sizes for the sparse decoder path
package sparse_mac_pkg;

    localparam int DEC_LANES   = 4;
    localparam int DEC_SKIP_W  = 8;
    localparam int DEC_VALUE_W = 8;
    localparam int DEC_INDEX_W = 16;
    localparam int DEC_VEC_LEN = 1024;

    typedef struct packed {
        logic [DEC_SKIP_W-1:0]  skip;
        logic [DEC_VALUE_W-1:0] value;
    } dec_lane_t;

    typedef struct packed {
        logic [DEC_INDEX_W-1:0] index;
        logic [DEC_VALUE_W-1:0] value;
    } dec_out_lane_t;

endpackage

// File: rtl/skid_buffer_sync.sv
// rtl/skid_buffer_sync.sv - two-entry synchronous skid buffer with a registered ready
module skid_buffer_sync #(
    parameter int DATA_W = 8
) (
    input  logic              mac_clk,
    input  logic              mac_rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;
    assign valid_o = (count != 2'd0);
    assign data_o  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // ready is taken from the next occupancy so upstream never sees the
    // downstream ready combinationally
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_o <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            ready_o <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/sparse_decoder_vec.sv
// rtl/sparse_decoder_vec.sv - multi-lane (skip,value) to (index,value) decoder; option DECODER_BOUNDS_CHECK_EN
module sparse_decoder_vec
    import sparse_mac_pkg::*;
#(
    parameter int LANES   = DEC_LANES,
    parameter int SKIP_W  = DEC_SKIP_W,
    parameter int VALUE_W = DEC_VALUE_W,
    parameter int INDEX_W = DEC_INDEX_W,
    parameter int VEC_LEN = DEC_VEC_LEN
) (
    input  logic                     mac_clk,
    input  logic                     mac_rst,
    input  logic                     sram_valid_i,
    output logic                     sram_ready_o,
    input  logic [LANES*SKIP_W-1:0]  sram_skip_i,
    input  logic [LANES*VALUE_W-1:0] sram_value_i,
    input  logic [LANES-1:0]         sram_mask_i,
    input  logic                     sram_last_i,
    output logic                     decoder_valid_o,
    input  logic                     decoder_ready_i,
    output logic [LANES*INDEX_W-1:0] decoder_index_o,
    output logic [LANES*VALUE_W-1:0] decoder_value_o,
    output logic [LANES-1:0]         decoder_mask_o,
    output logic                     decoder_last_o,
    output logic                     decoder_err_o
);

    localparam int FULL_W   = INDEX_W + $clog2(LANES) + 1;
    localparam int VAL_LSB  = LANES * INDEX_W;
    localparam int MASK_LSB = VAL_LSB + LANES * VALUE_W;
    localparam int LAST_BIT = MASK_LSB + LANES;
`ifdef DECODER_BOUNDS_CHECK_EN
    localparam int BEAT_W   = LAST_BIT + 2;
`else
    localparam int BEAT_W   = LAST_BIT + 1;
`endif

    if (LANES < 1 || longint'(VEC_LEN) > (longint'(1) << INDEX_W)) begin : g_bad_params
        $error("sparse_decoder_vec: LANES must be >= 1 and VEC_LEN <= 2**INDEX_W");
    end

    logic                     s1_valid;
    logic [LANES*SKIP_W-1:0]  s1_skip;
    logic [LANES*VALUE_W-1:0] s1_value;
    logic [LANES-1:0]         s1_mask;
    logic                     s1_last;
    logic [INDEX_W-1:0]       nxt;

    logic                     skid_ready;
    logic                     accept;
    logic                     xfer;

    logic [FULL_W-1:0]        acc;
    logic [LANES*INDEX_W-1:0] lane_index;
    logic [LANES*VALUE_W-1:0] lane_value;
    logic [BEAT_W-1:0]        beat_in;
    logic [BEAT_W-1:0]        beat_out;
`ifdef DECODER_BOUNDS_CHECK_EN
    logic [FULL_W-1:0]        full;
    logic                     s1_err;
`endif

    assign sram_ready_o = ~s1_valid | skid_ready;
    assign accept       = sram_valid_i & sram_ready_o;
    assign xfer         = s1_valid & skid_ready;

    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            s1_valid <= 1'b0;
            s1_skip  <= '0;
            s1_value <= '0;
            s1_mask  <= '0;
            s1_last  <= 1'b0;
            nxt      <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_skip  <= sram_skip_i;
                s1_value <= sram_value_i;
                s1_mask  <= sram_mask_i;
                s1_last  <= sram_last_i;
            end else if (xfer) begin
                s1_valid <= 1'b0;
            end
            if (xfer) begin
                nxt <= s1_last ? '0 : nxt + acc[INDEX_W-1:0];
            end
        end
    end

    // acc runs as the inclusive prefix sum over masked lanes; its final
    // value is the total advance of nxt for this beat
    always_comb begin
        acc        = '0;
        lane_index = '0;
        lane_value = '0;
`ifdef DECODER_BOUNDS_CHECK_EN
        full       = '0;
        s1_err     = 1'b0;
`endif
        for (int k = 0; k < LANES; k++) begin
            if (s1_mask[k]) begin
                acc = acc + FULL_W'(s1_skip[k*SKIP_W +: SKIP_W]) + FULL_W'(1);
`ifdef DECODER_BOUNDS_CHECK_EN
                full = FULL_W'(nxt) + acc - FULL_W'(1);
                lane_index[k*INDEX_W +: INDEX_W] = full[INDEX_W-1:0];
                if (full >= FULL_W'(VEC_LEN)) begin
                    s1_err = 1'b1;
                end
`else
                lane_index[k*INDEX_W +: INDEX_W] = INDEX_W'(FULL_W'(nxt) + acc - FULL_W'(1));
`endif
                lane_value[k*VALUE_W +: VALUE_W] = s1_value[k*VALUE_W +: VALUE_W];
            end
        end
    end

`ifdef DECODER_BOUNDS_CHECK_EN
    assign beat_in       = {s1_err, s1_last, s1_mask, lane_value, lane_index};
    assign decoder_err_o = beat_out[LAST_BIT+1];
`else
    assign beat_in       = {s1_last, s1_mask, lane_value, lane_index};
    assign decoder_err_o = 1'b0;
`endif

    skid_buffer_sync #(
        .DATA_W (BEAT_W)
    ) u_skid (
        .mac_clk (mac_clk),
        .mac_rst (mac_rst),
        .valid_i (s1_valid),
        .ready_o (skid_ready),
        .data_i  (beat_in),
        .valid_o (decoder_valid_o),
        .ready_i (decoder_ready_i),
        .data_o  (beat_out)
    );

    assign decoder_index_o = beat_out[VAL_LSB-1:0];
    assign decoder_value_o = beat_out[MASK_LSB-1:VAL_LSB];
    assign decoder_mask_o  = beat_out[LAST_BIT-1:MASK_LSB];
    assign decoder_last_o  = beat_out[LAST_BIT];

endmodule

// File: tb/tb_sparse_decoder_vec.sv
// tb/tb_sparse_decoder_vec.sv - randomized bench for sparse_decoder_vec against an arithmetic reference model
module tb_sparse_decoder_vec;

    localparam int L  = 4;
    localparam int SW = 8;
    localparam int VW = 8;
    localparam int IW = 16;
    localparam int VL = 16;
`ifdef DECODER_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic            mac_clk = 1'b0;
    logic            mac_rst = 1'b1;
    logic            sram_valid_i = 1'b0;
    logic            sram_ready_o;
    logic [L*SW-1:0] sram_skip_i = '0;
    logic [L*VW-1:0] sram_value_i = '0;
    logic [L-1:0]    sram_mask_i = '0;
    logic            sram_last_i = 1'b0;
    logic            decoder_valid_o;
    logic            decoder_ready_i = 1'b1;
    logic [L*IW-1:0] decoder_index_o;
    logic [L*VW-1:0] decoder_value_o;
    logic [L-1:0]    decoder_mask_o;
    logic            decoder_last_o;
    logic            decoder_err_o;

    sparse_decoder_vec #(
        .LANES   (L),
        .SKIP_W  (SW),
        .VALUE_W (VW),
        .INDEX_W (IW),
        .VEC_LEN (VL)
    ) dut (
        .mac_clk         (mac_clk),
        .mac_rst         (mac_rst),
        .sram_valid_i    (sram_valid_i),
        .sram_ready_o    (sram_ready_o),
        .sram_skip_i     (sram_skip_i),
        .sram_value_i    (sram_value_i),
        .sram_mask_i     (sram_mask_i),
        .sram_last_i     (sram_last_i),
        .decoder_valid_o (decoder_valid_o),
        .decoder_ready_i (decoder_ready_i),
        .decoder_index_o (decoder_index_o),
        .decoder_value_o (decoder_value_o),
        .decoder_mask_o  (decoder_mask_o),
        .decoder_last_o  (decoder_last_o),
        .decoder_err_o   (decoder_err_o)
    );

    always #5 mac_clk = ~mac_clk;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [63:0] idx;
        logic [31:0] val;
        logic [3:0]  mask;
        logic        last;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          nxt_m = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] held_idx;
    logic [63:0] held_rest;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: each masked lane lands (skip+1) past the previous one.
    always @(negedge mac_clk) begin
        if (mac_rst) begin
            q.delete();
            nxt_m      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", decoder_valid_o, 1);
                check("hold_index", decoder_index_o, held_idx);
                check("hold_rest", {decoder_value_o, decoder_mask_o, decoder_last_o, decoder_err_o}, held_rest);
            end
            prev_stall = decoder_valid_o && !decoder_ready_i;
            held_idx   = decoder_index_o;
            held_rest  = {decoder_value_o, decoder_mask_o, decoder_last_o, decoder_err_o};
            if (decoder_valid_o && decoder_ready_i) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_index", decoder_index_o, e.idx);
                    check("out_value", decoder_value_o, e.val);
                    check("out_mask", decoder_mask_o, e.mask);
                    check("out_last", decoder_last_o, e.last);
                    check("out_err", decoder_err_o, e.err);
                end
            end
            if (sram_valid_i && sram_ready_o) begin
                exp_t e;
                int   pos;
                int   full;
                e   = '{default: 0};
                pos = nxt_m;
                e.mask = sram_mask_i;
                e.last = sram_last_i;
                for (int k = 0; k < L; k++) begin
                    if (sram_mask_i[k]) begin
                        pos  = pos + int'(sram_skip_i[k*SW +: SW]) + 1;
                        full = pos - 1;
                        e.idx[k*IW +: IW] = full[IW-1:0];
                        e.val[k*VW +: VW] = sram_value_i[k*VW +: VW];
                        if (BOUNDS && full >= VL) e.err = 1'b1;
                    end
                end
                nxt_m = sram_last_i ? 0 : pos % 65536;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge mac_clk);
        #1;
        if (rand_ready) decoder_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic put(input logic [31:0] skip, input logic [31:0] value, input logic [3:0] mask, input logic last);
        sram_valid_i = 1'b1;
        sram_skip_i  = skip;
        sram_value_i = value;
        sram_mask_i  = mask;
        sram_last_i  = last;
    endtask

    task automatic send(input logic [31:0] skip, input logic [31:0] value, input logic [3:0] mask, input logic last);
        bit ok;
        ok = 1'b0;
        put(skip, value, mask, last);
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge mac_clk);
            ok = sram_ready_o;
            tick();
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic expect_beat(input string tag, input int lane, input logic [15:0] exp_idx, input logic exp_err);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge mac_clk);
            if (decoder_valid_o) begin
                check(tag, decoder_index_o[lane*IW +: IW], exp_idx);
                check({tag, "_err"}, decoder_err_o, exp_err);
                found = 1'b1;
            end
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
        tick();
    endtask

    logic [31:0] b_skip [6];
    logic [31:0] b_val  [6];
    logic [3:0]  b_mask [6];

    initial begin
        int n;
        bit ok;

        tick();
        tick();
        mac_rst = 1'b0;
        @(negedge mac_clk);
        check("rst_valid", decoder_valid_o, 0);
        check("rst_ready", sram_ready_o, 1);
        check("rst_index", decoder_index_o, 0);
        check("rst_rest", {decoder_value_o, decoder_mask_o, decoder_last_o, decoder_err_o}, 0);
        tick();

        // 1: two-lane beat, latency and first-beat indices
        send({8'd0, 8'd0, 8'd4, 8'd3}, {8'd0, 8'd0, 8'd6, 8'd5}, 4'b0011, 1'b1);
        sram_valid_i = 1'b0;
        @(negedge mac_clk);
        check("t1_lat_early", decoder_valid_o, 0);
        @(negedge mac_clk);
        check("t1_lat", decoder_valid_o, 1);
        check("t1_index", decoder_index_o, {16'd0, 16'd0, 16'd8, 16'd3});
        check("t1_value", decoder_value_o, {8'd0, 8'd0, 8'd6, 8'd5});
        tick();
        send(32'd2, 32'h77, 4'b0001, 1'b1);
        sram_valid_i = 1'b0;
        expect_beat("t1_next", 0, 16'd2, 1'b0);

        // 2: all lanes skip 0, then continue the vector
        send(32'd0, 32'h04030201, 4'b1111, 1'b0);
        sram_valid_i = 1'b0;
        expect_beat("t2_a_l3", 3, 16'd3, 1'b0);
        send(32'd2, 32'h09, 4'b0001, 1'b1);
        sram_valid_i = 1'b0;
        expect_beat("t2_b", 0, 16'd6, 1'b0);

        // 3: hole in the mask
        send({8'd1, 8'd9, 8'd1, 8'd1}, 32'h44332211, 4'b1011, 1'b0);
        sram_valid_i = 1'b0;
        @(negedge mac_clk);
        @(negedge mac_clk);
        check("t3_index", decoder_index_o, {16'd5, 16'd0, 16'd3, 16'd1});
        check("t3_value", decoder_value_o, 32'h44002211);
        tick();
        send(32'd0, 32'h55, 4'b0001, 1'b1);
        sram_valid_i = 1'b0;
        expect_beat("t3_adv", 0, 16'd6, 1'b0);

        // 4: back-pressure fills s1 plus both skid entries
        for (int i = 0; i < 6; i++) begin
            b_skip[i] = $urandom & 32'h03030303;
            b_val[i]  = $urandom;
            b_mask[i] = 4'($urandom_range(1, 15));
        end
        decoder_ready_i = 1'b0;
        n = 0;
        put(b_skip[0], b_val[0], b_mask[0], 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge mac_clk);
            ok = sram_ready_o;
            tick();
            if (ok) begin
                n++;
                put(b_skip[n], b_val[n], b_mask[n], n == 5);
            end
        end
        check("t4_accepted", n, 3);
        @(negedge mac_clk);
        check("t4_ready_low", sram_ready_o, 0);
        tick();
        decoder_ready_i = 1'b1;
        for (int i = n; i < 6; i++) send(b_skip[i], b_val[i], b_mask[i], i == 5);
        sram_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // 5: crossing VEC_LEN
        send(32'd15, 32'h11, 4'b0001, 1'b0);
        sram_valid_i = 1'b0;
        expect_beat("t5_a", 0, 16'd15, 1'b0);
        send(32'd0, 32'h22, 4'b0001, 1'b1);
        sram_valid_i = 1'b0;
        expect_beat("t5_b", 0, 16'd16, BOUNDS);

        // 6: reset with the pipeline full
        decoder_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom & 32'h03030303, $urandom, 4'b1111, 1'b0);
        sram_valid_i = 1'b0;
        @(negedge mac_clk);
        check("t6_full", sram_ready_o, 0);
        tick();
        mac_rst = 1'b1;
        tick();
        mac_rst = 1'b0;
        @(negedge mac_clk);
        check("t6_valid", decoder_valid_o, 0);
        check("t6_ready", sram_ready_o, 1);
        tick();
        decoder_ready_i = 1'b1;
        send(32'd2, 32'h66, 4'b0001, 1'b0);
        sram_valid_i = 1'b0;
        expect_beat("t6_after", 0, 16'd2, 1'b0);
        send(32'd0, 32'h01, 4'b0000, 1'b1);

        // random traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] sk;
            if ($urandom_range(0, 4) == 0) begin
                sram_valid_i = 1'b0;
                tick();
            end
            for (int k = 0; k < L; k++) begin
                sk[k*SW +: SW] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            end
            send(sk, $urandom, 4'($urandom), $urandom_range(0, 7) == 0);
        end

        // long vector to exercise index wrap-around
        for (int i = 0; i < 70; i++) send(32'hFFFFFFFF, $urandom, 4'b1111, 1'b0);
        send(32'd0, 32'd0, 4'b0000, 1'b1);

        rand_ready      = 1'b0;
        decoder_ready_i = 1'b1;
        sram_valid_i    = 1'b0;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
